spi_slave_if: RTL

Serial front end of the SPI slave. It deserialises MOSI frames into 10-bit words and hands each word to RAM_SPI over the din/rx_valid pair. When RAM_SPI returns read data on dout/tx_valid, the block serialises that byte back on MISO. It sits directly upstream and downstream of RAM_SPI. SPI SCK is the block clock.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_slave_if_if.sv | 34 +++
 rtl/spi_tx_serializer.sv | 59 +++++
 rtl/spi_slave_if.sv | 139 +++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

  localparam int unsigned DEF_ADDR_SIZE = 8;
  localparam int unsigned FRAME_W       = DEF_ADDR_SIZE + 2;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if_if.sv
// SPI pins plus the RAM_SPI-facing word handshake of the SPI slave front end.
interface spi_slave_if_if #(
  parameter int unsigned ADDR_SIZE = 8
) ();

  logic                 ss_n;
  logic                 mosi;
  logic                 miso;
  logic [ADDR_SIZE+1:0] rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;

  modport slave (
    input  ss_n,
    input  mosi,
    output miso,
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid
  );

  modport master (
    output ss_n,
    output mosi,
    input  miso,
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid
  );

endinterface

// File: rtl/spi_tx_serializer.sv
// Load-on-valid parallel-to-serial shifter, MSB first, with a sticky done flag.
module spi_tx_serializer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  output logic             serial_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(Width + 1);

  logic [Width-1:0] sh_d, sh_q;
  logic [CntW-1:0]  cnt_d, cnt_q;
  logic             done_d, done_q;

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr_i) begin
      sh_d   = '0;
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (load_i) begin
      sh_d   = data_i;
      cnt_d  = CntW'(Width);
      done_d = 1'b0;
    end else if (cnt_q != '0) begin
      sh_d  = {sh_q[Width-2:0], 1'b0};
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Line is held low whenever no bit is in flight.
  assign busy_o   = (cnt_q != '0);
  assign serial_o = busy_o & sh_q[Width-1];
  assign done_o   = done_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises command frames for RAM_SPI and returns read bytes on MISO.
// Optional SPI_FRAME_ERR_EN adds a frame_err pulse on aborted frames or read returns.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  spi_slave_if_if.slave bus
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic          frame_err
`endif
);

  localparam int unsigned FrameW = ADDR_SIZE + 2;
  localparam int unsigned CntW   = $clog2(FrameW + 1);

  spi_state_e        state_d, state_q;
  logic [CntW-1:0]   cnt_d, cnt_q;
  logic [FrameW-2:0] shift_d, shift_q;
  logic [FrameW-1:0] rx_data_d, rx_data_q;
  logic              rx_valid_d, rx_valid_q;
  logic              rd_seen_d, rd_seen_q;
  logic              frame_done;
  logic              ser_clr, ser_load, ser_busy, ser_done, ser_out;
`ifdef SPI_FRAME_ERR_EN
  logic              err_d, err_q;
`endif

  // Counter parks at FrameW once a frame is complete; extra bits are ignored.
  assign frame_done = (cnt_q == CntW'(FrameW));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rd_seen_d  = rd_seen_q;
    ser_clr    = 1'b0;
    ser_load   = 1'b0;
`ifdef SPI_FRAME_ERR_EN
    err_d      = 1'b0;
`endif
    if (bus.ss_n) begin
      state_d = StIdle;
      cnt_d   = '0;
      shift_d = '0;
      ser_clr = 1'b1;
`ifdef SPI_FRAME_ERR_EN
      err_d   = ((state_q != StIdle) && !frame_done) || ser_busy;
`endif
    end else begin
      case (state_q)
        StIdle: state_d = StChkCmd;
        StChkCmd: begin
          shift_d = {{(FrameW-2){1'b0}}, bus.mosi};
          cnt_d   = CntW'(1);
          if (!bus.mosi) begin
            state_d = StWrite;
          end else if (rd_seen_q) begin
            state_d = StReadData;
          end else begin
            state_d = StReadAdd;
          end
        end
        StWrite, StReadAdd, StReadData: begin
          if (!frame_done) begin
            shift_d = {shift_q[FrameW-3:0], bus.mosi};
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CntW'(FrameW - 1)) begin
              rx_data_d  = {shift_q, bus.mosi};
              rx_valid_d = 1'b1;
              if (state_q == StReadAdd) begin
                rd_seen_d = 1'b1;
              end else if (state_q == StReadData) begin
                rd_seen_d = 1'b0;
              end
            end
          end else if (state_q == StReadData && bus.tx_valid && !ser_busy && !ser_done) begin
            // Only one byte is returned per read-data frame.
            ser_load = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rd_seen_q  <= rd_seen_d;
    end
  end

`ifdef SPI_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign frame_err = err_q;
`endif

  spi_tx_serializer #(
    .Width (ADDR_SIZE)
  ) u_tx_ser (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (ser_clr),
    .load_i   (ser_load),
    .data_i   (bus.tx_data),
    .serial_o (ser_out),
    .busy_o   (ser_busy),
    .done_o   (ser_done)
  );

  assign bus.miso     = ser_out;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule
